// File: rtl/cam_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cam_fifo_arbiter
// Purpose  : Round-robin, row-burst arbiter that shares one pixel-FIFO write
//            port between two capture engines and tags each word with its
//            camera ID. Optional statistics counters: CAM_FIFO_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cam_fifo_arbiter #(
  parameter int DATA_W      = 16,
  parameter int MAX_BURST   = 112,
  parameter int BURST_CNT_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cam0_req,
  input  logic [DATA_W-1:0] cam0_data,
  input  logic              cam0_last,
  output logic              cam0_grant,
  input  logic              cam1_req,
  input  logic [DATA_W-1:0] cam1_data,
  input  logic              cam1_last,
  output logic              cam1_grant,
  input  logic              fifo_afull,
  output logic              fifo_wren,
  output logic [DATA_W:0]   fifo_wdata,
  output logic              busy,
  output logic [1:0]        tp_arb_state
`ifdef CAM_FIFO_ARB_STATS_EN
  ,
  output logic [31:0]       cam0_words,
  output logic [31:0]       cam1_words,
  output logic [15:0]       stall_cycles
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  localparam logic [BURST_CNT_W-1:0] BURST_LAST = BURST_CNT_W'(MAX_BURST - 1);

  arb_state_e             state_q, state_d;
  logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic                   last_served_q, last_served_d;
  logic                   wren_q;
  logic [DATA_W:0]        wdata_q, wdata_d;

  logic xfer0, xfer1, xfer, xfer_last, burst_at_max;

  assign cam0_grant   = (state_q == ST_OWN0) && !fifo_afull;
  assign cam1_grant   = (state_q == ST_OWN1) && !fifo_afull;
  assign xfer0        = cam0_req && cam0_grant;
  assign xfer1        = cam1_req && cam1_grant;
  assign xfer         = xfer0 || xfer1;
  assign xfer_last    = xfer1 ? cam1_last : cam0_last;
  assign burst_at_max = (burst_cnt_q == BURST_LAST);
  assign wdata_d      = xfer1 ? {1'b1, cam1_data} : {1'b0, cam0_data};

  always_comb begin
    state_d       = state_q;
    burst_cnt_d   = burst_cnt_q;
    last_served_d = last_served_q;
    case (state_q)
      ST_IDLE: begin
        burst_cnt_d = '0;
        // On a tie the camera that was not served last wins.
        if (cam0_req && (!cam1_req || last_served_q)) begin
          state_d = ST_OWN0;
        end else if (cam1_req) begin
          state_d = ST_OWN1;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (xfer) begin
          if (xfer_last || burst_at_max) begin
            state_d       = ST_IDLE;
            last_served_d = (state_q == ST_OWN1);
            burst_cnt_d   = '0;
          end else begin
            burst_cnt_d = burst_cnt_q + BURST_CNT_W'(1);
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        burst_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      burst_cnt_q   <= '0;
      last_served_q <= 1'b1;
      wren_q        <= 1'b0;
      wdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      burst_cnt_q   <= burst_cnt_d;
      last_served_q <= last_served_d;
      wren_q        <= xfer;
      if (xfer) begin
        wdata_q <= wdata_d;
      end
    end
  end

  assign fifo_wren    = wren_q;
  assign fifo_wdata   = wdata_q;
  assign busy         = (state_q != ST_IDLE);
  assign tp_arb_state = state_q;

`ifdef CAM_FIFO_ARB_STATS_EN
  logic [31:0] cam0_words_q, cam1_words_q;
  logic [15:0] stall_cycles_q;
  logic        owner_stalled;

  // A stall is a cycle where the current owner wants to send but afull blocks it.
  assign owner_stalled = fifo_afull &&
                         (((state_q == ST_OWN0) && cam0_req) ||
                          ((state_q == ST_OWN1) && cam1_req));

  always_ff @(posedge clk) begin
    if (reset) begin
      cam0_words_q   <= '0;
      cam1_words_q   <= '0;
      stall_cycles_q <= '0;
    end else begin
      if (xfer0 && (cam0_words_q != '1)) begin
        cam0_words_q <= cam0_words_q + 32'd1;
      end
      if (xfer1 && (cam1_words_q != '1)) begin
        cam1_words_q <= cam1_words_q + 32'd1;
      end
      if (owner_stalled && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + 16'd1;
      end
    end
  end

  assign cam0_words   = cam0_words_q;
  assign cam1_words   = cam1_words_q;
  assign stall_cycles = stall_cycles_q;
`endif

endmodule
`default_nettype wire
